// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;

    // Framing FSM states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    // Values reported on o_error_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Frame start marker used when the top is not overridden
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte watchdog: counts idle cycles while a frame is open and flags
// the cycle whose clock edge would bring the count to TIMEOUT_CYCLES, so the
// owner registers the error exactly TIMEOUT_CYCLES cycles after the last byte.
module rx_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Idle-cycle counter; held at zero outside a frame and on every byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (i_clear || !i_enable) begin
            count <= '0;
        end else if (count != CW'(TIMEOUT_CYCLES)) begin
            count <= count + CW'(1);
        end
    end

    assign o_expired = i_enable && !i_clear && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/program_loader.sv
// Receives a framed byte stream, writes 16-bit words into program memory
// from address 0, and keeps the CPU in reset until a frame checks out.
module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDRESS_BITS   = 11,
    parameter int         DATA_BITS      = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_wr_en,
    output logic [ADDRESS_BITS-1:0] o_wr_address,
    output logic [DATA_BITS-1:0]    o_wr_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [1:0]              o_error_code,
    output logic                    o_cpu_rst
);

    // Largest legal word count is the full memory depth
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDRESS_BITS;

    state_t                state;
    logic [7:0]            chk_acc;
    logic [7:0]            len_hi;
    logic [7:0]            data_hi;
    logic [ADDRESS_BITS:0] len_words;
    logic [ADDRESS_BITS:0] word_cnt;
    logic [ADDRESS_BITS:0] word_cnt_next;
    logic [15:0]           n_words;
    logic                  len_bad;
    logic                  in_frame;
    logic                  expired;

    assign n_words       = {len_hi, i_rx_data};
    assign len_bad       = (n_words == 16'd0) || ({1'b0, n_words} > MAX_WORDS);
    assign word_cnt_next = word_cnt + (ADDRESS_BITS + 1)'(1);
    assign in_frame      = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                           (state == S_DATA_HI) || (state == S_DATA_LO) ||
                           (state == S_CHECK);

    rx_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_enable (in_frame),
        .i_clear  (i_rx_valid),
        .o_expired(expired)
    );

    // Framing FSM with registered status, write port and checksum tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            chk_acc      <= '0;
            len_hi       <= '0;
            data_hi      <= '0;
            len_words    <= '0;
            word_cnt     <= '0;
            o_wr_en      <= 1'b0;
            o_wr_address <= '0;
            o_wr_data    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_error_code <= ERR_NONE;
            o_cpu_rst    <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            if (i_rx_valid) begin
                case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (i_rx_data == SYNC_BYTE) begin
                            state        <= S_LEN_HI;
                            chk_acc      <= '0;
                            word_cnt     <= '0;
                            o_busy       <= 1'b1;
                            o_done       <= 1'b0;
                            o_error      <= 1'b0;
                            o_error_code <= ERR_NONE;
                            o_cpu_rst    <= 1'b0;
                        end
                    end
                    S_LEN_HI: begin
                        len_hi  <= i_rx_data;
                        chk_acc <= chk_acc ^ i_rx_data;
                        state   <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        chk_acc <= chk_acc ^ i_rx_data;
                        if (len_bad) begin
                            state        <= S_ERROR;
                            o_busy       <= 1'b0;
                            o_error      <= 1'b1;
                            o_error_code <= ERR_LEN;
                        end else begin
                            len_words <= n_words[ADDRESS_BITS:0];
                            state     <= S_DATA_HI;
                        end
                    end
                    S_DATA_HI: begin
                        data_hi <= i_rx_data;
                        chk_acc <= chk_acc ^ i_rx_data;
                        state   <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        chk_acc      <= chk_acc ^ i_rx_data;
                        o_wr_en      <= 1'b1;
                        o_wr_data    <= {data_hi, i_rx_data};
                        o_wr_address <= word_cnt[ADDRESS_BITS-1:0];
                        word_cnt     <= word_cnt_next;
                        state        <= (word_cnt_next == len_words) ? S_CHECK : S_DATA_HI;
                    end
                    S_CHECK: begin
                        o_busy <= 1'b0;
                        if (i_rx_data == chk_acc) begin
                            state     <= S_DONE;
                            o_done    <= 1'b1;
                            o_cpu_rst <= 1'b1;
                        end else begin
                            state        <= S_ERROR;
                            o_error      <= 1'b1;
                            o_error_code <= ERR_CHK;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (expired) begin
                state        <= S_ERROR;
                o_busy       <= 1'b0;
                o_error      <= 1'b1;
                o_error_code <= ERR_TIMEOUT;
            end
        end
    end

endmodule
